// File: rtl/diff_pulse_trigger_if.sv
// Event handshake bundle between the pulse trigger (master) and the event packer (slave).
// The payload is held stable by the master while event_valid is high and event_ready is low.
interface diff_pulse_trigger_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 20,
    parameter int TS_WIDTH     = 48
);
    localparam int LANE_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                  event_valid;
    logic                  event_ready;
    logic [TS_WIDTH-1:0]   event_ts;
    logic [LANE_W-1:0]     event_lane;
    logic [DATA_WIDTH-1:0] event_peak;

    modport master (
        output event_valid,
        output event_ts,
        output event_lane,
        output event_peak,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_ts,
        input  event_lane,
        input  event_peak,
        output event_ready
    );
endinterface

// File: rtl/diff_pulse_trigger.sv
// Rising-crossing trigger on the difference bus with windowed peak search of the minuend; two stages.
// Never stalls upstream: beats arriving while an event is pending are tracked but cannot trigger.
module diff_pulse_trigger #(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 20,
    parameter int TS_WIDTH     = 48,
    parameter int PEAK_WINDOW  = 8,
    parameter int HOLDOFF      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0]            threshold,
    input  logic                             enable,
    diff_pulse_trigger_if.master             ev,
    output logic                             busy,
    output logic [15:0]                      missed_cnt
);
    localparam int LANE_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int WIN_W  = $clog2(PEAK_WINDOW + 1);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEAK = 2'd1,
        EMIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // ---------------- stage 1: compare, crossing, lane maxima ----------------
    logic [NUM_CHANNELS-1:0]       f_d;
    logic [NUM_CHANNELS-1:0]       cross_d;
    logic [LANE_W-1:0]             lane_d;
    logic signed [DATA_WIDTH-1:0]  smax_d [NUM_CHANNELS];
    logic signed [DATA_WIDTH-1:0]  tail_d;

    logic [TS_WIDTH-1:0]           cnt_q;
    logic                          prev_f_q;
    logic                          s1_vld_q;
    logic                          s1_any_q;
    logic                          s1_en_q;
    logic [LANE_W-1:0]             s1_lane_q;
    logic [TS_WIDTH-1:0]           s1_ts_q;
    logic signed [DATA_WIDTH-1:0]  s1_tail_q;
    logic signed [DATA_WIDTH-1:0]  s1_full_q;

    always_comb begin
        f_d    = '0;
        lane_d = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            f_d[k] = $signed(diff_in[k*DATA_WIDTH +: DATA_WIDTH]) > $signed(threshold);
        end
        // lane 0 compares against the last lane of the previous valid beat
        cross_d = f_d & ~{f_d[NUM_CHANNELS-2:0], prev_f_q};
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (cross_d[k]) lane_d = LANE_W'(k);
        end
        smax_d[NUM_CHANNELS-1] = $signed(data_in[(NUM_CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH]);
        for (int k = NUM_CHANNELS - 2; k >= 0; k--) begin
            smax_d[k] = ($signed(data_in[k*DATA_WIDTH +: DATA_WIDTH]) >= smax_d[k+1])
                      ? $signed(data_in[k*DATA_WIDTH +: DATA_WIDTH]) : smax_d[k+1];
        end
        tail_d = smax_d[lane_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            prev_f_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_any_q  <= 1'b0;
            s1_en_q   <= 1'b0;
            s1_lane_q <= '0;
            s1_ts_q   <= '0;
            s1_tail_q <= '0;
            s1_full_q <= '0;
        end else begin
            s1_vld_q <= valid_in;
            if (valid_in) begin
                cnt_q     <= cnt_q + TS_WIDTH'(NUM_CHANNELS);
                prev_f_q  <= f_d[NUM_CHANNELS-1];
                s1_any_q  <= |cross_d;
                s1_en_q   <= enable;
                s1_lane_q <= lane_d;
                s1_ts_q   <= cnt_q + TS_WIDTH'(lane_d);
                s1_tail_q <= tail_d;
                s1_full_q <= smax_d[0];
            end
        end
    end

    // ---------------- stage 2: trigger FSM ----------------
    state_t                        state_q;
    logic [WIN_W-1:0]              win_q;
    logic [HOLD_W-1:0]             hold_q;
    logic                          ev_vld_q;
    logic                          busy_q;
    logic [TS_WIDTH-1:0]           ts_q;
    logic [LANE_W-1:0]             lane_q;
    logic signed [DATA_WIDTH-1:0]  peak_q;
    logic [15:0]                   missed_q;
    logic                          trig_ok;

    assign trig_ok = (state_q == IDLE) && s1_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            hold_q   <= '0;
            ev_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            ts_q     <= '0;
            lane_q   <= '0;
            peak_q   <= '0;
            missed_q <= '0;
        end else begin
            if (s1_vld_q && s1_any_q && !trig_ok && (missed_q != 16'hFFFF)) begin
                missed_q <= missed_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (s1_vld_q && s1_en_q && s1_any_q) begin
                        ts_q   <= s1_ts_q;
                        lane_q <= s1_lane_q;
                        peak_q <= s1_tail_q;
                        busy_q <= 1'b1;
                        win_q  <= WIN_W'(PEAK_WINDOW - 1);
                        if (PEAK_WINDOW == 1) begin
                            state_q  <= EMIT;
                            ev_vld_q <= 1'b1;
                        end else begin
                            state_q <= PEAK;
                        end
                    end
                end
                PEAK: begin
                    if (s1_vld_q) begin
                        if (s1_full_q > peak_q) peak_q <= s1_full_q;
                        win_q <= win_q - WIN_W'(1);
                        if (win_q == WIN_W'(1)) begin
                            state_q  <= EMIT;
                            ev_vld_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (ev_vld_q && ev.event_ready) begin
                        ev_vld_q <= 1'b0;
                        hold_q   <= HOLD_W'(HOLDOFF);
                        if (HOLDOFF == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (s1_vld_q) begin
                        hold_q <= hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    ev_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign ev.event_valid = ev_vld_q;
    assign ev.event_ts    = ts_q;
    assign ev.event_lane  = lane_q;
    assign ev.event_peak  = peak_q;
    assign busy           = busy_q;
    assign missed_cnt     = missed_q;
endmodule

// File: tb/tb_diff_pulse_trigger.sv
// Directed bench for diff_pulse_trigger: single pulse timing, lane-boundary continuation,
// backpressure, signed threshold, reset mid-window, holdoff and enable gating.
module tb_diff_pulse_trigger;
    localparam int N  = 16;
    localparam int DW = 20;
    localparam int TW = 48;
    localparam int BW = N * DW;

    localparam logic [DW-1:0] P200 = 20'sd200;
    localparam logic [DW-1:0] M200 = -20'sd200;
    localparam logic [DW-1:0] M100 = -20'sd100;
    localparam logic [DW-1:0] M50  = -20'sd50;
    localparam logic [DW-1:0] M500 = -20'sd500;
    localparam logic [DW-1:0] M30  = -20'sd30;
    localparam logic [DW-1:0] T100 = 20'sd100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [BW-1:0] diff_in;
    logic [BW-1:0] data_in;
    logic [DW-1:0] threshold;
    logic          enable;
    logic          busy;
    logic [15:0]   missed_cnt;

    int nchk = 0;
    int nerr = 0;
    int bidx = 0;
    int trig;
    logic seen;

    logic [BW-1:0] q0, d10, qn, dn, pp;

    diff_pulse_trigger_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .TS_WIDTH(TW)) ev_if ();

    diff_pulse_trigger #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .TS_WIDTH(TW), .PEAK_WINDOW(8), .HOLDOFF(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .diff_in    (diff_in),
        .data_in    (data_in),
        .threshold  (threshold),
        .enable     (enable),
        .ev         (ev_if),
        .busy       (busy),
        .missed_cnt (missed_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
        logic [BW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] setr(input logic [BW-1:0] b, input int lo, input int hi,
                                           input logic [DW-1:0] v);
        logic [BW-1:0] r;
        r = b;
        for (int k = lo; k <= hi; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    task automatic beat(input logic v, input logic [BW-1:0] d, input logic [BW-1:0] x);
        valid_in = v;
        diff_in  = d;
        data_in  = x;
        @(posedge clk);
        #1;
        if (v) bidx++;
    endtask

    task automatic wait_ev(input string tag, input logic [BW-1:0] d, input logic [BW-1:0] x);
        int n;
        n = 0;
        while (!ev_if.event_valid && n < 40) begin
            beat(1'b1, d, x);
            n++;
        end
        chk({tag, "_arrive"}, 64'(ev_if.event_valid), 64'd1);
    endtask

    task automatic quiet(input int n, input logic [BW-1:0] d, input logic [BW-1:0] x);
        for (int i = 0; i < n; i++) beat(1'b1, d, x);
    endtask

    initial begin
        q0  = fill(20'd0);
        d10 = fill(20'd10);
        qn  = fill(M500);
        dn  = fill(M30);
        pp  = setr(q0, 0, 7, P200);

        rst_n = 1'b0; valid_in = 1'b0; diff_in = '0; data_in = '0;
        threshold = T100; enable = 1'b1; ev_if.event_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ev_if.event_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_missed", 64'(missed_cnt), 64'd0);
        chk("rst_ts",    64'(ev_if.event_ts), 64'd0);
        chk("rst_lane",  64'(ev_if.event_lane), 64'd0);
        chk("rst_peak",  64'(ev_if.event_peak), 64'd0);
        rst_n = 1'b1;

        // 1: single pulse at beat 5 lane 3, exact latency and width
        quiet(5, q0, d10);
        beat(1'b1, setr(q0, 3, 15, P200), d10);
        beat(1'b1, q0, d10);
        beat(1'b1, q0, setr(d10, 9, 9, 20'd4000));
        quiet(5, q0, d10);
        chk("t1_early", 64'(ev_if.event_valid), 64'd0);
        beat(1'b1, q0, d10);
        chk("t1_valid", 64'(ev_if.event_valid), 64'd1);
        chk("t1_ts",    64'(ev_if.event_ts), 64'd83);
        chk("t1_lane",  64'(ev_if.event_lane), 64'd3);
        chk("t1_peak",  64'(ev_if.event_peak), 64'd4000);
        chk("t1_busy",  64'(busy), 64'd1);
        beat(1'b1, q0, d10);
        chk("t1_width", 64'(ev_if.event_valid), 64'd0);
        chk("t1_hold_busy", 64'(busy), 64'd1);
        quiet(6, q0, d10);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_missed", 64'(missed_cnt), 64'd0);

        // 2: crossing on lane 15, continuation into lane 0 across invalid beats
        trig = bidx;
        beat(1'b1, setr(q0, 15, 15, P200), setr(setr(d10, 3, 3, 20'd900), 15, 15, 20'd50));
        repeat (3) beat(1'b0, fill(P200), fill(20'd5000));
        beat(1'b1, setr(q0, 0, 0, P200), d10);
        wait_ev("t2", q0, d10);
        chk("t2_ts",   64'(ev_if.event_ts), 64'(trig * 16 + 15));
        chk("t2_lane", 64'(ev_if.event_lane), 64'd15);
        chk("t2_peak", 64'(ev_if.event_peak), 64'd50);
        chk("t2_missed", 64'(missed_cnt), 64'd0);
        quiet(6, q0, d10);
        chk("t2_done", 64'(ev_if.event_valid), 64'd0);

        // 3: backpressure with a second pulse arriving during EMIT
        ev_if.event_ready = 1'b0;
        trig = bidx;
        beat(1'b1, setr(q0, 8, 15, P200), setr(d10, 12, 12, 20'd77));
        wait_ev("t3", q0, d10);
        for (int i = 0; i < 20; i++) begin
            if (i == 3)      beat(1'b1, setr(q0, 2, 15, P200), fill(20'd9999));
            else if (i % 2)  beat(1'b0, fill(P200), fill(20'd9999));
            else             beat(1'b1, q0, fill(20'd9999));
            chk("t3_valid", 64'(ev_if.event_valid), 64'd1);
            chk("t3_ts",    64'(ev_if.event_ts), 64'(trig * 16 + 8));
            chk("t3_lane",  64'(ev_if.event_lane), 64'd8);
            chk("t3_peak",  64'(ev_if.event_peak), 64'd77);
        end
        chk("t3_missed", 64'(missed_cnt), 64'd1);
        ev_if.event_ready = 1'b1;
        beat(1'b1, q0, d10);
        chk("t3_drop", 64'(ev_if.event_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            beat(1'b1, q0, d10);
            seen = seen | ev_if.event_valid;
        end
        chk("t3_no_second", 64'(seen), 64'd0);

        // 4: negative threshold and all-negative peak
        threshold = M100;
        beat(1'b1, qn, dn);
        trig = bidx;
        beat(1'b1, setr(setr(qn, 0, 5, M200), 6, 15, M50), dn);
        wait_ev("t4", qn, dn);
        chk("t4_lane", 64'(ev_if.event_lane), 64'd6);
        chk("t4_ts",   64'(ev_if.event_ts), 64'(trig * 16 + 6));
        chk("t4_peak", 64'(ev_if.event_peak), 64'(M30));
        quiet(6, qn, dn);
        threshold = T100;
        beat(1'b1, q0, d10);
        chk("t4_missed", 64'(missed_cnt), 64'd1);

        // 5: reset in the middle of the peak window
        beat(1'b1, setr(q0, 4, 15, P200), d10);
        quiet(3, q0, d10);
        chk("t5_busy_pre", 64'(busy), 64'd1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(ev_if.event_valid), 64'd0);
        chk("t5_busy",  64'(busy), 64'd0);
        chk("t5_missed", 64'(missed_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bidx = 0;
        quiet(2, q0, d10);
        beat(1'b1, setr(q0, 4, 15, P200), setr(setr(d10, 0, 0, 20'd300), 10, 10, 20'd120));
        wait_ev("t5", q0, d10);
        chk("t5_ts",   64'(ev_if.event_ts), 64'd36);
        chk("t5_lane", 64'(ev_if.event_lane), 64'd4);
        chk("t5_peak", 64'(ev_if.event_peak), 64'd120);
        quiet(6, q0, d10);

        // 6: four holdoff beats ignored, fifth triggers
        beat(1'b1, pp, d10);
        wait_ev("t6a", q0, d10);
        for (int i = 0; i < 5; i++) begin
            trig = bidx;
            beat(1'b1, pp, d10);
        end
        chk("t6_missed", 64'(missed_cnt), 64'd4);
        wait_ev("t6b", q0, d10);
        chk("t6_ts",   64'(ev_if.event_ts), 64'(trig * 16));
        chk("t6_lane", 64'(ev_if.event_lane), 64'd0);
        quiet(6, q0, d10);

        // 7: enable low blocks new triggers and counts the crossing as missed
        enable = 1'b0;
        beat(1'b1, pp, d10);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, q0, d10);
            seen = seen | ev_if.event_valid;
        end
        chk("t7_no_event", 64'(seen), 64'd0);
        chk("t7_missed", 64'(missed_cnt), 64'd5);
        chk("t7_busy", 64'(busy), 64'd0);
        enable = 1'b1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
